// File: rtl/baud_cfg_ctrl.sv
// rtl/baud_cfg_ctrl.sv - divisor load sequencer for the SPART baud rate generator
module baud_cfg_ctrl #(
    parameter logic [15:0] DIV0       = 16'd2603,
    parameter logic [15:0] DIV1       = 16'd1301,
    parameter logic [15:0] DIV2       = 16'd651,
    parameter logic [15:0] DIV3       = 16'd325,
    parameter int          SETTLE_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  baud_sel,
    input  logic        wr_req,
    input  logic [15:0] wr_div,
    output logic        wr_ack,
    output logic        wr_err,
    output logic        brg_load_high,
    output logic        brg_load_low,
    output logic [7:0]  brg_data,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        brg_valid,
    output logic [15:0] cur_div
);

    typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO, SETTLE} state_t;

    localparam logic [4:0] SETTLE_LAST = 5'(SETTLE_CYC - 1);

    state_t      state;
    logic        pend_wr;
    logic        pend_sel;
    logic [15:0] pend_div;
    logic [15:0] work_div;
    logic [1:0]  sel_q;
    logic [4:0]  settle_cnt;
    logic [15:0] sel_div;
    logic [15:0] svc_div;
    logic        wr_ok;

    always_comb begin
        sel_div = DIV0;
        case (sel_q)
            2'd0:    sel_div = DIV0;
            2'd1:    sel_div = DIV1;
            2'd2:    sel_div = DIV2;
            default: sel_div = DIV3;
        endcase
    end

    // Host writes win over switch changes; the loser stays pending.
    assign svc_div = pend_wr ? pend_div : sel_div;
    assign wr_ok   = (wr_div >= 16'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pend_wr       <= 1'b0;
            pend_sel      <= 1'b1;
            pend_div      <= '0;
            work_div      <= '0;
            sel_q         <= baud_sel;
            settle_cnt    <= '0;
            wr_ack        <= 1'b0;
            wr_err        <= 1'b0;
            brg_load_high <= 1'b0;
            brg_load_low  <= 1'b0;
            brg_data      <= '0;
            cfg_busy      <= 1'b0;
            cfg_done      <= 1'b0;
            brg_valid     <= 1'b0;
            cur_div       <= 16'h028B;
        end else begin
            wr_ack   <= wr_req && wr_ok;
            wr_err   <= wr_req && !wr_ok;
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_wr || pend_sel) begin
                        work_div <= svc_div;
                        if (pend_wr) pend_wr  <= 1'b0;
                        else         pend_sel <= 1'b0;
                        state         <= LOAD_HI;
                        brg_load_high <= 1'b1;
                        brg_data      <= svc_div[15:8];
                        cfg_busy      <= 1'b1;
                        brg_valid     <= 1'b0;
                    end
                end
                LOAD_HI: begin
                    state         <= LOAD_LO;
                    brg_load_high <= 1'b0;
                    brg_load_low  <= 1'b1;
                    brg_data      <= work_div[7:0];
                end
                LOAD_LO: begin
                    state        <= SETTLE;
                    brg_load_low <= 1'b0;
                    brg_data     <= '0;
                    cur_div      <= work_div;
                    settle_cnt   <= '0;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state     <= IDLE;
                        cfg_busy  <= 1'b0;
                        cfg_done  <= 1'b1;
                        brg_valid <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            // New requests are recorded last so they win over a same-cycle service clear.
            if (wr_req && wr_ok) begin
                pend_wr  <= 1'b1;
                pend_div <= wr_div;
            end
            if (baud_sel != sel_q) begin
                pend_sel <= 1'b1;
                sel_q    <= baud_sel;
            end
        end
    end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// tb/tb_baud_cfg_ctrl.sv - self-checking bench for baud_cfg_ctrl
module tb_baud_cfg_ctrl;

    localparam int S = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  baud_sel = 2'd2;
    logic        wr_req = 1'b0;
    logic [15:0] wr_div = 16'd0;
    logic        wr_ack, wr_err, brg_load_high, brg_load_low;
    logic [7:0]  brg_data;
    logic        cfg_busy, cfg_done, brg_valid;
    logic [15:0] cur_div;

    int n_cmp = 0;
    int n_bad = 0;
    int excl_viol = 0;

    baud_cfg_ctrl #(.SETTLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .baud_sel(baud_sel), .wr_req(wr_req), .wr_div(wr_div),
        .wr_ack(wr_ack), .wr_err(wr_err), .brg_load_high(brg_load_high),
        .brg_load_low(brg_load_low), .brg_data(brg_data), .cfg_busy(cfg_busy),
        .cfg_done(cfg_done), .brg_valid(brg_valid), .cur_div(cur_div)
    );

    always #5 clk = ~clk;

    // Reference model: sequence position counted in cycles since the load began.
    bit          m_pw, m_ps, m_done, m_valid, m_ack, m_err;
    logic [15:0] m_pdiv = '0, m_div = '0, m_cur = 16'h028B;
    logic [1:0]  m_sel;
    int          m_phase = 0;

    function automatic logic [15:0] div_of(input logic [1:0] s);
        case (s)
            2'd0:    return 16'd2603;
            2'd1:    return 16'd1301;
            2'd2:    return 16'd651;
            default: return 16'd325;
        endcase
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_pw = 0; m_ps = 1; m_sel = baud_sel; m_phase = 0;
            m_done = 0; m_valid = 0; m_ack = 0; m_err = 0; m_cur = 16'h028B;
        end else begin
            m_done = 0;
            if (m_phase == 0) begin
                if (m_pw) begin
                    m_div = m_pdiv; m_pw = 0; m_phase = 1; m_valid = 0;
                end else if (m_ps) begin
                    m_div = div_of(m_sel); m_ps = 0; m_phase = 1; m_valid = 0;
                end
            end else if (m_phase == 2 + S) begin
                m_phase = 0; m_done = 1; m_valid = 1;
            end else begin
                if (m_phase == 2) m_cur = m_div;
                m_phase++;
            end
            m_ack = wr_req && (wr_div >= 16'd2);
            m_err = wr_req && (wr_div < 16'd2);
            if (m_ack) begin m_pw = 1; m_pdiv = wr_div; end
            if (baud_sel != m_sel) begin m_ps = 1; m_sel = baud_sel; end
        end
    endtask

    function automatic logic [30:0] model_vec();
        logic hi, lo;
        logic [7:0] d;
        hi = (m_phase == 1);
        lo = (m_phase == 2);
        d  = hi ? m_div[15:8] : (lo ? m_div[7:0] : 8'h00);
        return {m_ack, m_err, hi, lo, d, (m_phase != 0), m_done, m_valid, m_cur};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (brg_load_high && brg_load_low) excl_viol++;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (cfg_done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; baud_sel = 2'd2;
        repeat (3) tick();
        n_cmp++;
        if ({wr_ack, wr_err, brg_load_high, brg_load_low, brg_data, cfg_busy, cfg_done, brg_valid} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {wr_ack, wr_err, brg_load_high, brg_load_low, brg_data, cfg_busy, cfg_done, brg_valid});
        end
        n_cmp++;
        if (cur_div !== 16'h028B) begin
            n_bad++; $display("FAIL reset_cur_div: got %h expected 028b", cur_div);
        end
    endtask

    task automatic test_boot();
        int n;
        rst = 0;
        tick();
        n_cmp++;
        if ({brg_load_high, brg_load_low, brg_data, cfg_busy, brg_valid} !== {1'b1, 1'b0, 8'h02, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL boot_hi: got hi=%b lo=%b data=%h busy=%b valid=%b expected 1 0 02 1 0",
                              brg_load_high, brg_load_low, brg_data, cfg_busy, brg_valid);
        end
        tick();
        n_cmp++;
        if ({brg_load_high, brg_load_low, brg_data} !== {1'b0, 1'b1, 8'h8B}) begin
            n_bad++; $display("FAIL boot_lo: got hi=%b lo=%b data=%h expected 0 1 8b",
                              brg_load_high, brg_load_low, brg_data);
        end
        wait_done(n);
        n_cmp++;
        if (n !== 17 || cur_div !== 16'd651 || brg_valid !== 1'b1) begin
            n_bad++; $display("FAIL boot_done: got ticks=%0d cur=%0d valid=%b expected 17 651 1", n, cur_div, brg_valid);
        end
        tick();
        n_cmp++;
        if ({cfg_done, brg_valid, cfg_busy} !== 3'b010) begin
            n_bad++; $display("FAIL boot_done_pulse: got done=%b valid=%b busy=%b expected 0 1 0", cfg_done, brg_valid, cfg_busy);
        end
    endtask

    task automatic test_host_write();
        int n;
        wr_req = 1; wr_div = 16'h0145;
        tick();
        wr_req = 0;
        n_cmp++;
        if ({wr_ack, wr_err, cfg_busy} !== 3'b100) begin
            n_bad++; $display("FAIL wr_ack: got ack=%b err=%b busy=%b expected 1 0 0", wr_ack, wr_err, cfg_busy);
        end
        tick();
        n_cmp++;
        if ({wr_ack, brg_load_high, brg_data, brg_valid} !== {1'b0, 1'b1, 8'h01, 1'b0}) begin
            n_bad++; $display("FAIL wr_hi: got ack=%b hi=%b data=%h valid=%b expected 0 1 01 0", wr_ack, brg_load_high, brg_data, brg_valid);
        end
        tick();
        n_cmp++;
        if ({brg_load_low, brg_data} !== {1'b1, 8'h45}) begin
            n_bad++; $display("FAIL wr_lo: got lo=%b data=%h expected 1 45", brg_load_low, brg_data);
        end
        wait_done(n);
        n_cmp++;
        if (n !== 17 || cur_div !== 16'h0145) begin
            n_bad++; $display("FAIL wr_done: got ticks=%0d cur=%h expected 17 0145", n, cur_div);
        end
    endtask

    task automatic test_collision();
        int n1, n2;
        baud_sel = 2'd3; wr_req = 1; wr_div = 16'd1000;
        tick();
        wr_req = 0;
        tick();
        n_cmp++;
        if ({brg_load_high, brg_data} !== {1'b1, 8'h03}) begin
            n_bad++; $display("FAIL coll_hi1: got hi=%b data=%h expected 1 03", brg_load_high, brg_data);
        end
        tick();
        n_cmp++;
        if ({brg_load_low, brg_data} !== {1'b1, 8'hE8}) begin
            n_bad++; $display("FAIL coll_lo1: got lo=%b data=%h expected 1 e8", brg_load_low, brg_data);
        end
        wait_done(n1);
        n_cmp++;
        if (n1 !== 17 || cur_div !== 16'd1000) begin
            n_bad++; $display("FAIL coll_done1: got ticks=%0d cur=%0d expected 17 1000", n1, cur_div);
        end
        tick();
        n_cmp++;
        if ({brg_load_high, brg_data, cfg_busy} !== {1'b1, 8'h01, 1'b1}) begin
            n_bad++; $display("FAIL coll_hi2: got hi=%b data=%h busy=%b expected 1 01 1", brg_load_high, brg_data, cfg_busy);
        end
        tick();
        n_cmp++;
        if ({brg_load_low, brg_data} !== {1'b1, 8'h45}) begin
            n_bad++; $display("FAIL coll_lo2: got lo=%b data=%h expected 1 45", brg_load_low, brg_data);
        end
        wait_done(n2);
        n_cmp++;
        if (n2 !== 17 || cur_div !== 16'd325) begin
            n_bad++; $display("FAIL coll_done2: got ticks=%0d cur=%0d expected 17 325", n2, cur_div);
        end
        tick();
        n_cmp++;
        if ({cfg_busy, cfg_done} !== 2'b00) begin
            n_bad++; $display("FAIL coll_idle: got busy=%b done=%b expected 0 0", cfg_busy, cfg_done);
        end
    endtask

    task automatic test_reject_overwrite();
        int n;
        wr_req = 1; wr_div = 16'd1;
        tick();
        wr_req = 0;
        n_cmp++;
        if ({wr_ack, wr_err} !== 2'b01) begin
            n_bad++; $display("FAIL rej_err: got ack=%b err=%b expected 0 1", wr_ack, wr_err);
        end
        repeat (4) tick();
        n_cmp++;
        if ({cfg_busy, wr_err, cur_div} !== {1'b0, 1'b0, 16'd325}) begin
            n_bad++; $display("FAIL rej_noseq: got busy=%b err=%b cur=%0d expected 0 0 325", cfg_busy, wr_err, cur_div);
        end
        wr_req = 1; wr_div = 16'd300;
        tick();
        wr_req = 0;
        repeat (3) tick();
        wr_req = 1; wr_div = 16'd500;
        tick();
        wr_div = 16'd700;
        tick();
        wr_req = 0;
        wait_done(n);
        n_cmp++;
        if (cur_div !== 16'd300) begin
            n_bad++; $display("FAIL ovr_first: got cur=%0d expected 300", cur_div);
        end
        tick();
        n_cmp++;
        if ({brg_load_high, brg_data} !== {1'b1, 8'h02}) begin
            n_bad++; $display("FAIL ovr_hi: got hi=%b data=%h expected 1 02", brg_load_high, brg_data);
        end
        tick();
        n_cmp++;
        if ({brg_load_low, brg_data} !== {1'b1, 8'hBC}) begin
            n_bad++; $display("FAIL ovr_lo: got lo=%b data=%h expected 1 bc", brg_load_low, brg_data);
        end
        wait_done(n);
        repeat (3) tick();
        n_cmp++;
        if ({cfg_busy, cur_div} !== {1'b0, 16'd700}) begin
            n_bad++; $display("FAIL ovr_single: got busy=%b cur=%0d expected 0 700", cfg_busy, cur_div);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        wr_req = 1; wr_div = 16'd400;
        tick();
        wr_req = 0;
        repeat (4) tick();
        baud_sel = 2'd1; rst = 1;
        tick();
        n_cmp++;
        if ({wr_ack, wr_err, brg_load_high, brg_load_low, brg_data, cfg_busy, cfg_done, brg_valid, cur_div}
                !== {15'd0, 16'h028B}) begin
            n_bad++; $display("FAIL rstmid_vals: got busy=%b valid=%b data=%h cur=%h expected 0 0 00 028b",
                              cfg_busy, brg_valid, brg_data, cur_div);
        end
        rst = 0;
        tick();
        n_cmp++;
        if ({brg_load_high, brg_data} !== {1'b1, 8'h05}) begin
            n_bad++; $display("FAIL rstmid_hi: got hi=%b data=%h expected 1 05", brg_load_high, brg_data);
        end
        tick();
        n_cmp++;
        if ({brg_load_low, brg_data} !== {1'b1, 8'h15}) begin
            n_bad++; $display("FAIL rstmid_lo: got lo=%b data=%h expected 1 15", brg_load_low, brg_data);
        end
        wait_done(n);
        n_cmp++;
        if (n !== 17 || cur_div !== 16'd1301 || brg_valid !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_done: got ticks=%0d cur=%0d valid=%b expected 17 1301 1", n, cur_div, brg_valid);
        end
    endtask

    task automatic test_random();
        logic [30:0] act, exp;
        int shown = 0;
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            wr_req = ($urandom_range(0, 7) == 0);
            wr_div = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            if ($urandom_range(0, 39) == 0) baud_sel = 2'($urandom_range(0, 3));
            tick();
            act = {wr_ack, wr_err, brg_load_high, brg_load_low, brg_data, cfg_busy, cfg_done, brg_valid, cur_div};
            exp = model_vec();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_cycle%0d: got %h expected %h", i, act, exp);
                end
            end
        end
        rst = 0; wr_req = 0;
        n_cmp++;
        if (excl_viol !== 0) begin
            n_bad++; $display("FAIL strobe_excl: got %0d overlapping cycles expected 0", excl_viol);
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_host_write();
        test_collision();
        test_reject_overwrite();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
